cam_capture: RTL
================

# cam_capture

Camera-side capture stage feeding the convolution pipeline. Samples an OV7670-style byte bus (vsync, href, 8-bit data) on the pixel clock and pairs bytes into RGB565 pixels. Converts each pixel to 8-bit grey and emits a `value`/`x`/`y`/`is_val` pixel stream with the same format `convolve` consumes. It replaces the simulated camera in hardware builds.

## Interface

Parameters:

- `WIDTH`, 320: active pixels per line that are forwarded.
- `HEIGHT`, 240: active lines per frame that are forwarded.

Ports:

- `clk`  in  1  pixel clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cam_vsync`  in  1  frame sync; high during vertical blanking.
- `cam_href`  in  1  high while line bytes are valid.
- `cam_data`  in  8  camera byte; RGB565, high byte first.
- `value`  out  8  grey pixel.
- `x`  out  10  pixel column, 0..WIDTH-1.
- `y`  out  10  pixel row, 0..HEIGHT-1.
- `is_val`  out  1  one-cycle strobe; `value`/`x`/`y` are valid when it is high.
- `frame_done`  out  1  one-cycle pulse at the end of a captured frame.
- `sync_err`  out  1  sticky flag: odd byte count seen on a line; cleared at frame start.

## Operation

- **Input stage.** `cam_vsync`, `cam_href` and `cam_data` are registered every cycle into `vsync_q`, `href_q`, `data_q`. All decisions use the registered copies.
- **FSM.**
  - `WAIT_FRAME`: leave this state on a `vsync_q` 1→0 edge. On that edge go to `ACTIVE`, clear x, y, byte phase and `sync_err`.
  - `ACTIVE`: on a `vsync_q` 0→1 edge, pulse `frame_done` and return to `WAIT_FRAME`.
- **Byte pairing.** In `ACTIVE` with `href_q` high:
  - Phase 0 stores `data_q` as the high byte.
  - Phase 1 forms the RGB565 word `{hi, data_q}`, converts it, and emits it if `x<WIDTH` and `y<HEIGHT`.
  - The phase toggles every byte.
- **Counters.**
  - x increments after every completed pair and saturates at WIDTH.
  - On an `href_q` 1→0 edge: y increments (saturating at HEIGHT), x←0, phase←0.
  - If phase was 1 on that edge, the dangling byte is dropped and `sync_err`←1.
- **Conversion.**
  - Expand channels: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
  - grey=(2·r8+5·g8+b8)>>3, computed in 11 bits; the result always fits in 8 bits.
- **Dropped data.**
  - Pixels with x≥WIDTH and lines with y≥HEIGHT produce no `is_val`.
  - Bytes while `href_q` is low, or in `WAIT_FRAME`, are ignored.
- **Simultaneous vsync rise and href fall:** the frame end wins and the counters are cleared at the next frame start.

## Timing

- **Latency:** a second byte present at the pins before edge t is in `data_q` after t. `is_val`, `value`, `x` and `y` are registered at edge t+1. That is 2 clocks pin-to-output.
- **Output rate:** at most one `is_val` per 2 clocks. `x` on an `is_val` cycle is the column of that pixel, before the increment.
- **`frame_done`:** high for exactly one cycle, the cycle after `vsync_q` rises while in `ACTIVE`.
- **Reset** (`reset`=0 at an edge): FSM←`WAIT_FRAME`; `value`, `x`, `y`, `is_val`, `frame_done`, `sync_err`, phase and input registers ←0.
- **Reset mid-frame:** the remainder of the current frame is discarded. Output resumes only after the next vsync falling edge.

## Structure

- Package `cam_pkg` holds:
  - RGB565 field positions (R 15:11, G 10:5, B 4:0).
  - Grey weights 2/5/1 and shift 3.
  - FSM state enum `WAIT_FRAME`/`ACTIVE`.
  - Coordinate width 10.
- Sub-module `rgb565_to_grey`: purely combinational 16→8 converter, instantiated once. Counters, FSM and output registers stay in `cam_capture`.

## Test plan

- **Primary colours.** Vsync fall, then one href line with byte pairs FF/FF, F8/00, 07/E0, 00/1F → `is_val` ×4 with `value` 255, 63, 159, 31 and x 0..3, y 0; each `is_val` 2 clocks after its second byte.
- **Full frame.** 240 lines of 640 bytes, then vsync rise → exactly 76800 `is_val`; last pixel x=319, y=239; single-cycle `frame_done`.
- **Clipping.** Line of 700 bytes and 250 lines → x never exceeds 319, y never exceeds 239; no `is_val` for the extra pixels or lines.
- **Odd line.** Line of 641 bytes → 320 pixels, `sync_err`=1 after the href fall. Next line pairs from phase 0. `sync_err` clears on the next vsync fall.
- **Mid-frame reset.** `reset`=0 for 1 cycle during line 100 → all outputs 0; no `is_val` until the next vsync fall, after which the frame restarts at x=0, y=0.
- **Before first vsync.** href activity before any vsync fall → no `is_val`, no `frame_done`.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture path.
//   - RGB565 field positions
//   - grey conversion weights and shift
//   - capture FSM state type
//   - pixel coordinate width
package cam_pkg;

  localparam int COORD_W = 10;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int GREY_W_R   = 2;
  localparam int GREY_W_G   = 5;
  localparam int GREY_W_B   = 1;
  localparam int GREY_SHIFT = 3;
  // 8*255 = 2040 is the largest weighted sum, so 11 bits suffice.
  localparam int GREY_SUM_W = 11;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } cam_state_t;

endpackage

// File: rtl/rgb565_to_grey.sv
// rgb565_to_grey: combinational RGB565 -> 8-bit grey.
// Ports:
//   i_rgb   in  16  RGB565 word (R 15:11, G 10:5, B 4:0)
//   o_grey  out  8  (2*R8 + 5*G8 + B8) >> 3
module rgb565_to_grey
  import cam_pkg::*;
(
  input  logic [15:0] i_rgb,
  output logic [7:0]  o_grey
);

  logic [4:0]            w_r5;
  logic [5:0]            w_g6;
  logic [4:0]            w_b5;
  logic [7:0]            w_r8;
  logic [7:0]            w_g8;
  logic [7:0]            w_b8;
  logic [GREY_SUM_W-1:0] w_sum;

  assign w_r5 = i_rgb[R_MSB:R_LSB];
  assign w_g6 = i_rgb[G_MSB:G_LSB];
  assign w_b5 = i_rgb[B_MSB:B_LSB];

  // Replicate the top bits so full-scale 5/6-bit values map to 255.
  assign w_r8 = {w_r5, w_r5[4:2]};
  assign w_g8 = {w_g6, w_g6[5:4]};
  assign w_b8 = {w_b5, w_b5[4:2]};

  assign w_sum = GREY_SUM_W'(GREY_W_R) * GREY_SUM_W'(w_r8)
               + GREY_SUM_W'(GREY_W_G) * GREY_SUM_W'(w_g8)
               + GREY_SUM_W'(GREY_W_B) * GREY_SUM_W'(w_b8);

  assign o_grey = 8'(w_sum >> GREY_SHIFT);

endmodule

// File: rtl/cam_capture.sv
// cam_capture: OV7670-style byte bus -> grey pixel stream.
// Ports:
//   clk         in   1  pixel clock
//   reset       in   1  synchronous, active-low
//   cam_vsync   in   1  frame sync, high in vertical blanking
//   cam_href    in   1  line bytes valid
//   cam_data    in   8  RGB565 byte, high byte first
//   value       out  8  grey pixel
//   x / y       out 10  pixel column / row
//   is_val      out  1  value/x/y strobe
//   frame_done  out  1  one-cycle end-of-frame pulse
//   sync_err    out  1  sticky odd-byte-line flag, cleared at frame start
//
// State      | Meaning
// WAIT_FRAME | idle until vsync falls; bus ignored
// ACTIVE     | pairing bytes into pixels until vsync rises
module cam_capture
  import cam_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cam_vsync,
  input  logic         cam_href,
  input  logic [7:0]   cam_data,
  output logic [7:0]   value,
  output logic [9:0]   x,
  output logic [9:0]   y,
  output logic         is_val,
  output logic         frame_done,
  output logic         sync_err
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(HEIGHT);

  cam_state_t         r_state;
  cam_state_t         w_state_next;
  logic               w_frame_start;
  logic               w_frame_end;

  logic               r_vsync_q;
  logic               r_href_q;
  logic [7:0]         r_data_q;
  logic               r_vsync_d;
  logic               r_href_d;

  logic               r_phase;
  logic [7:0]         r_hi;
  logic [COORD_W-1:0] r_x_cnt;
  logic [COORD_W-1:0] r_y_cnt;

  logic [7:0]         r_value;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_is_val;
  logic               r_frame_done;
  logic               r_sync_err;

  logic               w_vs_rise;
  logic               w_vs_fall;
  logic               w_href_fall;
  logic [7:0]         w_grey;

  assign w_vs_rise   =  r_vsync_q & ~r_vsync_d;
  assign w_vs_fall   = ~r_vsync_q &  r_vsync_d;
  assign w_href_fall = ~r_href_q  &  r_href_d;

  rgb565_to_grey u_grey (
    .i_rgb  ({r_hi, r_data_q}),
    .o_grey (w_grey)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= WAIT_FRAME;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      WAIT_FRAME: begin
        if (w_vs_fall) begin
          w_state_next  = ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_vs_rise) begin
          w_state_next = WAIT_FRAME;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vsync_q    <= 1'b0;
      r_href_q     <= 1'b0;
      r_data_q     <= '0;
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_value      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_is_val     <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_vsync_q    <= cam_vsync;
      r_href_q     <= cam_href;
      r_data_q     <= cam_data;
      r_vsync_d    <= r_vsync_q;
      r_href_d     <= r_href_q;
      r_is_val     <= 1'b0;
      r_frame_done <= w_frame_end;

      if (w_frame_start) begin
        r_x_cnt    <= '0;
        r_y_cnt    <= '0;
        r_phase    <= 1'b0;
        r_sync_err <= 1'b0;
      end else if (r_state == ACTIVE && !w_frame_end) begin
        // Frame end takes priority: a coincident href fall is left to the
        // next frame start, which clears the counters anyway.
        if (w_href_fall) begin
          r_x_cnt <= '0;
          r_phase <= 1'b0;
          if (r_y_cnt < Y_LIM) r_y_cnt <= r_y_cnt + COORD_W'(1);
          if (r_phase) r_sync_err <= 1'b1;
        end else if (r_href_q) begin
          if (!r_phase) begin
            r_hi    <= r_data_q;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_x_cnt < X_LIM && r_y_cnt < Y_LIM) begin
              r_is_val <= 1'b1;
              r_value  <= w_grey;
              r_x      <= r_x_cnt;
              r_y      <= r_y_cnt;
            end
            if (r_x_cnt < X_LIM) r_x_cnt <= r_x_cnt + COORD_W'(1);
          end
        end
      end
    end
  end

  assign value      = r_value;
  assign x          = r_x;
  assign y          = r_y;
  assign is_val     = r_is_val;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;

endmodule
